// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family and its read-side engine.
//   DEFAULT_DATA_WIDTH : default FIFO word / stream data width
//   DEFAULT_BURST_LEN  : default number of words per stream burst
//   occ_e              : occupancy of the 2-entry output buffer
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_BURST_LEN  = 10;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader_if
// Bundles the FIFO read-port and the outgoing valid/ready stream of
// fifo_stream_reader.
//   fifo_empty / fifo_data / fifo_r_en : FIFO read port
//   m_valid / m_ready / m_data / m_last : output stream
//   burst_cnt                           : words accepted in the current burst
// Modports:
//   master : the reader engine (drives r_en and the stream)
//   slave  : the environment (FIFO + downstream consumer)
// -----------------------------------------------------------------------------
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH,
   parameter int BURST_LEN  = fifo_pkg::DEFAULT_BURST_LEN
) ();

   localparam int CNT_W = $clog2(BURST_LEN + 1);

   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_r_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic [CNT_W-1:0]      burst_cnt;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_r_en, m_valid, m_data, m_last, burst_cnt
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_r_en, m_valid, m_data, m_last, burst_cnt
   );

endinterface

// File: rtl/stream_skid_buf.sv
// -----------------------------------------------------------------------------
// stream_skid_buf
// Two-entry in-order buffer holding words returned by the FIFO until the
// stream consumer takes them. Entry 0 is always the head.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   wr       : capture wdata at the tail this cycle
//   wdata    : word to capture
//   pop      : head word is consumed this cycle
//   head     : current head word (stream data)
//   occ      : occupancy EMPTY/ONE/TWO
//   m_valid  : buffer holds at least one word (registered)
// -----------------------------------------------------------------------------
module stream_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output occ_e                  occ,
   output logic                  m_valid
);

   occ_e                  state_q;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] entry_q [2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         valid_q    <= 1'b0;
         entry_q[0] <= '0;
         entry_q[1] <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               // Nothing to pop while empty; only a capture moves us.
               if (wr) begin
                  entry_q[0] <= wdata;
                  state_q    <= ONE;
                  valid_q    <= 1'b1;
               end
            end
            ONE: begin
               if (wr && pop) begin
                  // Head leaves and the returning word becomes the new head.
                  entry_q[0] <= wdata;
               end else if (wr) begin
                  entry_q[1] <= wdata;
                  state_q    <= TWO;
               end else if (pop) begin
                  state_q <= EMPTY;
                  valid_q <= 1'b0;
               end
            end
            TWO: begin
               if (pop) begin
                  entry_q[0] <= entry_q[1];
                  if (wr) begin
                     entry_q[1] <= wdata;
                  end else begin
                     state_q <= ONE;
                  end
               end
            end
            default: begin
               state_q <= EMPTY;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign head    = entry_q[0];
   assign occ     = state_q;
   assign m_valid = valid_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Drains a synchronous FIFO with a registered read port and presents its
// words as a valid/ready stream with a burst-boundary marker. The FIFO's
// one-cycle read latency is absorbed by a 2-entry buffer, which lets the
// engine sustain one word per cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fifo_stream_reader_if.master
//              (fifo_empty, fifo_data in; fifo_r_en out;
//               m_valid, m_data, m_last, burst_cnt out; m_ready in)
// -----------------------------------------------------------------------------
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BURST_LEN  = DEFAULT_BURST_LEN
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_stream_reader_if.master bus
);

   localparam int               CNT_W    = $clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

   occ_e                  occ;
   logic                  buf_valid;
   logic [DATA_WIDTH-1:0] head;
   logic                  pop;
   logic [2:0]            occ_sum;
   logic                  r_en;
   logic                  inflight_q, inflight_d;
   logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;

   always_comb begin
      pop = buf_valid & bus.m_ready;
      // Words that will be held after this edge, counting the one returning
      // now. Only issue a pop if its data will find a free slot next cycle.
      occ_sum = 3'(occ) + 3'(inflight_q) - 3'(pop);
      r_en    = !rst && !bus.fifo_empty && (occ_sum < 3'd2);

      inflight_d  = r_en;
      burst_cnt_d = burst_cnt_q;
      if (pop) begin
         burst_cnt_d = (burst_cnt_q == LAST_CNT) ? '0 : burst_cnt_q + CNT_W'(1);
      end
   end

   // Clearing inflight_q on reset drops the word returning right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q  <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         inflight_q  <= inflight_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .wr      (inflight_q),
      .wdata   (bus.fifo_data),
      .pop     (pop),
      .head    (head),
      .occ     (occ),
      .m_valid (buf_valid)
   );

   assign bus.fifo_r_en = r_en;
   assign bus.m_valid   = buf_valid;
   assign bus.m_data    = head;
   assign bus.m_last    = buf_valid & (burst_cnt_q == LAST_CNT);
   assign bus.burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Bench for fifo_stream_reader: a queue-based FIFO with a registered read
// port feeds the DUT; a scoreboard holds the words the stream must deliver,
// and a running word count gives the expected burst position and m_last.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

   localparam int DW = 8;
   localparam int BL = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m_ready = 1'b0;
   logic [DW-1:0] fifo_data;

   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DATA_WIDTH(DW), .BURST_LEN(BL)) bus ();

   fifo_stream_reader #(
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- FIFO model: registered read port ----------------
   logic [DW-1:0] fifo_q[$];
   int            push_total = 0;
   int            pop_total  = 0;

   assign bus.fifo_empty = (push_total == pop_total);
   assign bus.fifo_data  = fifo_data;
   assign bus.m_ready    = m_ready;

   always @(posedge clk) begin
      if (bus.fifo_r_en && (push_total != pop_total)) begin
         fifo_data <= fifo_q.pop_front();
         pop_total <= pop_total + 1;
      end
   end

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   int            model_cnt = 0;
   int            word_no = 0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] stall_data;
   logic          stall_last;

   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      push_total++;
   endtask

   always @(negedge clk) begin
      #2;
      if (rst) begin
         // Everything not still in the FIFO is lost on reset.
         exp_q      = fifo_q;
         model_cnt  = 0;
         stall_prev = 1'b0;
      end else begin
         check_val("burst_cnt", 32'(bus.burst_cnt), 32'(model_cnt));
         if (stall_prev) begin
            check_val("stall_valid", 32'(bus.m_valid), 32'd1);
            check_val("stall_data", 32'(bus.m_data), 32'(stall_data));
            check_val("stall_last", 32'(bus.m_last), 32'(stall_last));
         end
         if (bus.m_valid) begin
            check_val("last", 32'(bus.m_last), 32'(model_cnt == BL - 1));
         end
         if (bus.m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check_val("spurious_valid", 32'(bus.m_valid), 32'd0);
            end else begin
               word_no++;
               $display("tb: word %0d data=0x%02h last=%0d cnt=%0d",
                        word_no, bus.m_data, bus.m_last, bus.burst_cnt);
               check_val("data", 32'(bus.m_data), 32'(exp_q.pop_front()));
               model_cnt = (model_cnt == BL - 1) ? 0 : model_cnt + 1;
            end
         end
         stall_prev = bus.m_valid && !m_ready;
         stall_data = bus.m_data;
         stall_last = bus.m_last;
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_drain(input int max_cycles, input bit rnd);
      int c = 0;
      while ((exp_q.size() != 0 || bus.m_valid) && c < max_cycles) begin
         @(negedge clk);
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #3;
         c++;
      end
      check_val("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      m_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_stream();
      logic [DW-1:0] w;
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         w = (i == 0) ? 8'h24 : (i == 1) ? 8'h81 : (i == 2) ? 8'h09 : DW'($urandom);
         push_word(w);
         #2;
         if (i == 0)      check_val("lat_ren", 32'(bus.fifo_r_en), 32'd1);
         else if (i == 1) check_val("lat_novalid", 32'(bus.m_valid), 32'd0);
         else             check_val("stream_valid", 32'(bus.m_valid), 32'd1);
      end
      repeat (2) begin
         @(negedge clk); #2;
         check_val("stream_valid", 32'(bus.m_valid), 32'd1);
      end
      @(negedge clk); #2;
      check_val("stream_done", 32'(bus.m_valid), 32'd0);
      check_val("stream_cnt", 32'(bus.burst_cnt), 32'd0);
   endtask

   task automatic test_mid_reset();
      int c;
      m_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) push_word(DW'($urandom));
      c = 0;
      while (bus.burst_cnt != 4 && c < 30) begin
         @(negedge clk);
         c++;
      end
      m_ready = 1'b0;
      #2;
      check_val("rst_pre_cnt", 32'(bus.burst_cnt), 32'd4);
      repeat (2) @(negedge clk);
      #2;
      check_val("rst_pre_valid", 32'(bus.m_valid), 32'd1);
      check_val("rst_pre_fifo", 32'(fifo_q.size()), 32'd2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
      check_val("rst_valid", 32'(bus.m_valid), 32'd0);
      check_val("rst_cnt", 32'(bus.burst_cnt), 32'd0);
      wait_drain(20, 1'b0);

      // Reset while a popped word is in flight: it must never appear.
      @(negedge clk);
      for (int i = 0; i < 4; i++) push_word(DW'($urandom));
      c = 0;
      while (!bus.m_valid && c < 10) begin
         @(negedge clk);
         c++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
      check_val("rst2_valid", 32'(bus.m_valid), 32'd0);
      wait_drain(20, 1'b0);
   endtask

   task automatic test_backpressure();
      int p0;
      @(negedge clk);
      m_ready = 1'b0;
      p0 = pop_total;
      for (int i = 0; i < 5; i++) push_word(DW'($urandom));
      repeat (8) @(negedge clk);
      #2;
      check_val("bp_pops", 32'(pop_total - p0), 32'd2);
      check_val("bp_fifo", 32'(fifo_q.size()), 32'd3);
      check_val("bp_valid", 32'(bus.m_valid), 32'd1);
      check_val("bp_ren", 32'(bus.fifo_r_en), 32'd0);
      wait_drain(20, 1'b0);
   endtask

   task automatic test_random();
      int pushed = 0;
      int c = 0;
      do_reset();
      while (pushed < 40 && c < 2000) begin
         @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 6) begin
            push_word(DW'($urandom));
            pushed++;
         end
         c++;
      end
      wait_drain(400, 1'b1);
      @(negedge clk); #3;
      check_val("rand_cnt", 32'(bus.burst_cnt), 32'd0);
   endtask

   task automatic test_empty();
      @(negedge clk);
      m_ready = 1'b1;
      repeat (20) begin
         @(negedge clk); #2;
         check_val("empty_ren", 32'(bus.fifo_r_en), 32'd0);
         check_val("empty_valid", 32'(bus.m_valid), 32'd0);
      end
   endtask

   task automatic test_simul();
      logic [DW-1:0] w1, w2;
      w1 = DW'($urandom);
      w2 = w1 ^ 8'h5A;
      @(negedge clk);
      m_ready = 1'b0;
      push_word(w1);
      @(negedge clk);
      @(negedge clk);
      push_word(w2);
      #2;
      check_val("sim_one_valid", 32'(bus.m_valid), 32'd1);
      check_val("sim_ren", 32'(bus.fifo_r_en), 32'd1);
      @(negedge clk);
      m_ready = 1'b1;
      #2;
      check_val("sim_head", 32'(bus.m_data), 32'(w1));
      @(negedge clk);
      m_ready = 1'b0;
      #2;
      check_val("sim_hold", 32'(bus.m_valid), 32'd1);
      check_val("sim_adv", 32'(bus.m_data), 32'(w2));
      @(negedge clk); #2;
      check_val("sim_still_one", 32'(bus.m_valid), 32'd1);
      m_ready = 1'b1;
      wait_drain(10, 1'b0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #2;
      check_val("rst_r_en", 32'(bus.fifo_r_en), 32'd0);
      check_val("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check_val("rst_m_data", 32'(bus.m_data), 32'd0);
      check_val("rst_m_last", 32'(bus.m_last), 32'd0);
      check_val("rst_burst_cnt", 32'(bus.burst_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      test_stream();
      test_mid_reset();
      test_backpressure();
      test_random();
      test_empty();
      test_simul();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's synchronous FIFO. Issues `r_en` pops against the FIFO's registered read port and absorbs the one-cycle read latency in a 2-entry output buffer. Presents the words as a valid/ready stream with a burst-boundary marker. Sits between the FIFO's read port (`r_en`/`data_out`/`empty`) and any downstream consumer. Sustains one word per cycle under continuous `m_ready`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of FIFO words and stream data.
- `BURST_LEN`, 10, words per burst; `m_last` marks the final word of each burst. Legal range is ≥1.

Ports:
- `clk`  in  1  single clock for all state.
- `rst`  in  1  synchronous, active-high reset, sampled on rising `clk`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after a pop.
- `fifo_r_en`  out  1  pop request to the FIFO. Combinational.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_last`  out  1  current word is the BURST_LEN-th of its burst.
- `burst_cnt`  out  $clog2(BURST_LEN+1)  words accepted so far in the current burst.

## Operation
- **Occupancy state machine.** States are EMPTY (0 words), ONE (1 word) and TWO (2 words). A separate flag, `inflight`, records that a pop was issued last cycle and its data arrives this cycle.
- **Handshake.** `pop = m_valid & m_ready`. `m_valid = (state != EMPTY)`.
- **Pop request.** `fifo_r_en = !rst & !fifo_empty & (occ + inflight - pop < 2)`.
  - This guarantees no returning word is ever dropped.
  - `fifo_r_en` depends combinationally on `m_ready`.
- **Capture.** When `inflight` is 1, `fifo_data` is written into the buffer at the tail.
- **Stream order.** `m_data` always shows the head entry, and words leave in FIFO order.
- **State transitions on each edge:**
  - Next occupancy = `occ + inflight - pop`.
  - EMPTY→ONE on capture.
  - ONE→TWO on capture without pop.
  - ONE→EMPTY on pop without capture.
  - TWO→ONE on pop without capture.
  - Simultaneous capture and pop holds the state and shifts the buffer.
- **Burst counter.** `burst_cnt` increments on `pop`. On a pop with `burst_cnt == BURST_LEN-1` it wraps to 0. `m_last = m_valid & (burst_cnt == BURST_LEN-1)`.
- **Stream rule.** `m_data`/`m_last` hold stable while `m_valid & !m_ready`. `m_valid` never drops without a pop.

## Timing
- **Reset values.** `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `burst_cnt`=0, state EMPTY, `inflight`=0.
- **Reset behaviour.**
  - `rst` mid-operation discards buffered words and any in-flight word; the FIFO data returning in the cycle after reset is ignored.
  - Words already popped from the FIFO are lost, which is accepted behaviour.
- **Latency.** With `fifo_empty` first low in cycle N and the buffer in EMPTY:
  - `fifo_r_en`=1 in cycle N.
  - Data is captured at the edge ending cycle N+1.
  - `m_valid`=1 in cycle N+2.
- **Throughput.** One word per cycle while `!fifo_empty` and `m_ready`=1, with no bubbles after the first word.
- **Backpressure.** With `m_ready`=0, at most 2 words are buffered: 1 already held plus 1 in flight, or 2 held. `fifo_r_en` stays 0 until a pop frees space.
- **Empty FIFO.** Asserting `m_ready` while `fifo_empty`=1 drains the buffer, then `m_valid` falls. No pop is issued on empty.
- **Width rule.** `burst_cnt` never exceeds BURST_LEN-1. The sum `occ + inflight - pop` is computed in 3 bits.

## Structure
- **Shared package `fifo_pkg`.** Holds the default DATA_WIDTH and BURST_LEN constants and the occupancy enum (EMPTY/ONE/TWO). The sync FIFO and its bench import the same package.
- **Sub-module `stream_skid_buf`.** A 2-entry buffer that takes `wr`, `wdata` and `pop` and produces `head`, `occ`, `m_valid`. `fifo_stream_reader` instantiates it and owns the pop-request logic, `inflight` and the burst counter.
- **Target size.** About 150–250 lines of RTL in total.

## Test plan
- **Streaming.** Reset, then write 10 words 0x24, 0x81, 0x09, ... into the FIFO with `m_ready`=1.
  - All 10 words appear in order, on 10 consecutive cycles after the first.
  - `m_last`=1 only on the 10th word, and `burst_cnt` returns to 0.
- **Backpressure.** Hold `m_ready`=0 with 5 words in the FIFO. Required response:
  - `fifo_r_en` pulses exactly twice.
  - State reaches TWO, and the FIFO still holds 3 words.
  - After `m_ready`=1, words are delivered in order with no loss.
- **Mid-burst reset.** Apply `rst` for 1 cycle mid-burst, with `burst_cnt`=4 and the state in TWO.
  - The next cycle shows `m_valid`=0 and `burst_cnt`=0.
  - The word returning from the pre-reset pop is not presented.
  - The following words restart the count at 0.
- **Random `m_ready`.** Drive `m_ready` randomly at 50% over 40 words. Required response:
  - The output sequence matches the write sequence.
  - `m_data` stays stable during every stall.
  - `m_last` appears on words 10, 20, 30 and 40.
- **Empty FIFO.** With the FIFO empty and `m_ready`=1 for 20 cycles, `fifo_r_en` stays 0 and `m_valid` stays 0.
- **Simultaneous capture and pop.** One word is buffered (state ONE), `inflight`=1 and `m_ready`=1.
  - The state stays ONE.
  - `m_data` advances to the in-flight word on the next cycle.
